// File: rtl/fetcher_if.sv
// Bundle of signals between the instruction fetcher and the rest of the core.
//   Decoder side : stall (in), DecEn/inst/instPC (out)
//   Redirects    : jumpEn/jumpAddr, misTaken/misAddr (in)
//   Memory side  : memReq/memAddr (out), memGrant/memData (in)
// The master modport is the fetcher's view; slave is the environment's view.
interface fetcher_if;
    logic        stall;
    logic        jumpEn;
    logic [31:0] jumpAddr;
    logic        misTaken;
    logic [31:0] misAddr;
    logic        memGrant;
    logic [7:0]  memData;
    logic        memReq;
    logic [31:0] memAddr;
    logic        DecEn;
    logic [31:0] inst;
    logic [31:0] instPC;

    modport master (
        input  stall, jumpEn, jumpAddr, misTaken, misAddr, memGrant, memData,
        output memReq, memAddr, DecEn, inst, instPC
    );

    modport slave (
        output stall, jumpEn, jumpAddr, misTaken, misAddr, memGrant, memData,
        input  memReq, memAddr, DecEn, inst, instPC
    );
endinterface

// File: rtl/fetcher.sv
// Byte-serial instruction fetcher. Reads a 32-bit instruction as four byte
// requests (little-endian), pipelining requests while memGrant is high, and
// hands the assembled word to the decoder with a one-cycle DecEn pulse.
// Jumps and mispredicts redirect the PC from any state and drop any partial
// or held instruction.
//   clk      : single clock, rising edge
//   rst      : asynchronous, active-low reset
//   bus      : fetcher_if.master (memory, decoder and redirect signals)
//   RESET_PC : PC loaded on reset
module fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic      clk,
    input  logic      rst,
    fetcher_if.master bus
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  req_cnt_q, req_cnt_d;
    logic [2:0]  rcv_cnt_q, rcv_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        dec_en_q, dec_en_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic        byte_valid;
    logic [31:0] word_w;

    assign redirect    = bus.misTaken | bus.jumpEn;
    assign redirect_pc = bus.misTaken ? bus.misAddr : bus.jumpAddr;

    // Gating with rst keeps memReq low while reset is held, even though the
    // reset state itself (FETCH, reqCnt=0) would otherwise request.
    assign mem_req = rst & (state_q == FETCH) & (req_cnt_q < 3'd4) & ~redirect;

    // Data returns exactly one cycle after grant and at most one request is
    // issued per cycle, so a byte is on memData whenever rcvCnt lags reqCnt.
    assign byte_valid = (state_q == FETCH) & (rcv_cnt_q != req_cnt_q);

    // Assembly buffer with the incoming byte merged into lane rcvCnt.
    always_comb begin
        word_w = asm_q;
        case (rcv_cnt_q[1:0])
            2'd0:    word_w[7:0]   = bus.memData;
            2'd1:    word_w[15:8]  = bus.memData;
            2'd2:    word_w[23:16] = bus.memData;
            default: word_w[31:24] = bus.memData;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a hold/default value first so no path through
        // the branches below leaves a signal unassigned (no latches).
        state_d   = state_q;
        pc_d      = pc_q;
        req_cnt_d = req_cnt_q;
        rcv_cnt_d = rcv_cnt_q;
        asm_d     = asm_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        dec_en_d  = 1'b0;

        if (redirect) begin
            // Nothing is outstanding afterwards: memReq was gated this cycle,
            // and a byte arriving now belongs to the abandoned word.
            pc_d      = redirect_pc;
            req_cnt_d = 3'd0;
            rcv_cnt_d = 3'd0;
            asm_d     = 32'h0;
            state_d   = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_req && bus.memGrant) begin
                        req_cnt_d = req_cnt_q + 3'd1;
                    end
                    if (byte_valid) begin
                        asm_d     = word_w;
                        rcv_cnt_d = rcv_cnt_q + 3'd1;
                        if (rcv_cnt_q == 3'd3) begin
                            if (bus.stall) begin
                                // Word is complete but the decoder is busy;
                                // park it in the buffer until stall drops.
                                state_d = HOLD;
                            end else begin
                                inst_d    = word_w;
                                inst_pc_d = pc_q;
                                dec_en_d  = 1'b1;
                                pc_d      = pc_q + 32'd4;
                                req_cnt_d = 3'd0;
                                rcv_cnt_d = 3'd0;
                                asm_d     = 32'h0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        inst_d    = asm_q;
                        inst_pc_d = pc_q;
                        dec_en_d  = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        req_cnt_d = 3'd0;
                        rcv_cnt_d = 3'd0;
                        asm_d     = 32'h0;
                        state_d   = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            req_cnt_q <= 3'd0;
            rcv_cnt_q <= 3'd0;
            asm_q     <= 32'h0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            dec_en_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            asm_q     <= asm_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            dec_en_q  <= dec_en_d;
        end
    end

    assign bus.memReq  = mem_req;
    assign bus.memAddr = pc_q + {29'd0, req_cnt_q};
    assign bus.DecEn   = dec_en_q;
    assign bus.inst    = inst_q;
    assign bus.instPC  = inst_pc_q;

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed scenarios followed by randomized
// traffic, compared cycle by cycle against a transaction-level model.
module tb_fetcher;

    logic clk;
    logic rst;

    fetcher_if bus ();

    fetcher #(.RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: the word being fetched is identified only by
    // its start address and the number of granted byte requests so far.
    logic [31:0] m_pc;
    int          m_grants;     // granted requests for the current word
    logic        m_due;        // a granted byte is on memData this cycle
    logic        m_hold;       // complete word waiting for the decoder
    logic        m_dec;        // DecEn expected this cycle
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    logic [7:0]  data_next;    // memory response for the next cycle

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: the first word is an addi-nop (13 00 00 00), the rest a
    // scramble of the address so every byte lane is distinguishable.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] lo;
        if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
        lo = a[7:0] * 8'd37;
        return lo ^ a[15:8] ^ a[31:24] ^ 8'h5C;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2),
                mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // One clock cycle: drive inputs just after the falling edge, check at +1,
    // advance the model, then wait for the next falling edge.
    task automatic cycle(input logic st, input logic jen, input logic [31:0] ja,
                         input logic mis, input logic [31:0] ma, input logic gr);
        logic exp_req, granted, complete, dut_grant;
        logic [31:0] dut_addr;
        bus.stall    = st;
        bus.jumpEn   = jen;
        bus.jumpAddr = ja;
        bus.misTaken = mis;
        bus.misAddr  = ma;
        bus.memGrant = gr;
        bus.memData  = data_next;
        #1;
        exp_req = !m_hold && (m_grants < 4) && !(jen || mis);
        check("memReq", {31'd0, bus.memReq}, {31'd0, exp_req});
        if (exp_req) check("memAddr", bus.memAddr, m_pc + m_grants);
        check("DecEn", {31'd0, bus.DecEn}, {31'd0, m_dec});
        if (m_dec) begin
            check("inst", bus.inst, m_inst);
            check("instPC", bus.instPC, m_inst_pc);
        end
        dut_grant = bus.memReq && gr;
        dut_addr  = bus.memAddr;

        granted  = exp_req && gr;
        complete = m_due && (m_grants == 4) && !m_hold;
        m_dec    = 1'b0;
        if (jen || mis) begin
            m_pc     = mis ? ma : ja;
            m_grants = 0;
            m_hold   = 1'b0;
            m_due    = 1'b0;
        end else if (complete || m_hold) begin
            m_due = 1'b0;
            if (st) begin
                m_hold = 1'b1;
            end else begin
                m_dec     = 1'b1;
                m_inst    = word_at(m_pc);
                m_inst_pc = m_pc;
                m_pc      = m_pc + 32'd4;
                m_grants  = 0;
                m_hold    = 1'b0;
            end
        end else begin
            m_due = granted;
            if (granted) m_grants++;
        end

        // The memory answers whatever the DUT actually asked for; cycles
        // without a grant carry garbage that must be ignored.
        data_next = dut_grant ? mem_byte(dut_addr) : 8'($urandom);
        @(negedge clk);
    endtask

    task automatic run_n(input int n, input logic st, input logic gr);
        for (int i = 0; i < n; i++) cycle(st, 1'b0, 32'h0, 1'b0, 32'h0, gr);
    endtask

    // Holds reset for n cycles, checking the reset values of all outputs.
    task automatic do_reset(input int n);
        rst          = 1'b0;
        bus.stall    = 1'($urandom);
        bus.jumpEn   = 1'b0;
        bus.misTaken = 1'b0;
        bus.memGrant = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_memReq", {31'd0, bus.memReq}, 32'd0);
            check("rst_DecEn", {31'd0, bus.DecEn}, 32'd0);
            check("rst_inst", bus.inst, 32'h0);
            check("rst_instPC", bus.instPC, 32'h0);
            @(negedge clk);
        end
        rst       = 1'b1;
        m_pc      = 32'h0;
        m_grants  = 0;
        m_due     = 1'b0;
        m_hold    = 1'b0;
        m_dec     = 1'b0;
        m_inst    = 32'h0;
        m_inst_pc = 32'h0;
        data_next = 8'($urandom);
    endtask

    initial begin
        rst          = 1'b0;
        bus.stall    = 1'b0;
        bus.jumpEn   = 1'b0;
        bus.jumpAddr = 32'h0;
        bus.misTaken = 1'b0;
        bus.misAddr  = 32'h0;
        bus.memGrant = 1'b0;
        bus.memData  = 8'h0;
        @(negedge clk);

        // Straight-line fetch from reset: first word 0x00000013 at PC 0.
        do_reset(2);
        run_n(12, 1'b0, 1'b1);

        // Grant toggling every cycle stretches the fetch, losing no bytes.
        do_reset(1);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'(~i[0]));

        // Stall across fourth-byte capture, released three cycles later.
        do_reset(1);
        run_n(4, 1'b0, 1'b1);
        run_n(4, 1'b1, 1'b1);
        run_n(8, 1'b0, 1'b1);

        // Jump after two bytes were requested.
        do_reset(1);
        run_n(2, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        run_n(8, 1'b0, 1'b1);

        // Mispredict and jump together on the fourth-byte capture cycle.
        do_reset(1);
        run_n(4, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1);
        run_n(8, 1'b0, 1'b1);

        // Fetch at the top of the address space wraps to 0.
        do_reset(1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        run_n(10, 1'b0, 1'b1);

        // Redirect while holding a completed word.
        do_reset(1);
        run_n(4, 1'b0, 1'b1);
        run_n(2, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b1);
        run_n(8, 1'b0, 1'b1);

        // Randomized traffic with occasional redirects and resets.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] ja, ma;
            ja = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                             : $urandom;
            ma = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                cycle(1'($urandom_range(0, 9) < 3),
                      1'($urandom_range(0, 39) == 0), ja,
                      1'($urandom_range(0, 39) == 0), ma,
                      1'($urandom_range(0, 9) < 7));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
